// File: rtl/eth_frame_rx.sv
// eth_frame_rx: parses an Ethernet header (dest MAC, src MAC, EtherType)
// from a byte stream. The header comes out as a valid/ready bundle and the
// payload as a one-register-stage AXI-stream with SOF on tuser and EOF on tlast.
module eth_frame_rx #(
    parameter bit FILTER_EN = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [47:0] local_mac,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic        m_eth_hdr_valid,
    input  logic        m_eth_hdr_ready,
    output logic [47:0] m_eth_dest_mac,
    output logic [47:0] m_eth_src_mac,
    output logic [15:0] m_eth_type,
    output logic [7:0]  m_eth_axi_payload_tdata,
    output logic        m_eth_axi_payload_tvalid,
    input  logic        m_eth_axi_payload_tready,
    output logic        m_eth_axi_payload_tlast,
    output logic        m_eth_axi_payload_tuser,
    output logic        busy,
    output logic        err_hdr_early_termination
);

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       first_pl;
    logic       xfer;
    logic       dest_ok;

    assign xfer = s_axis_tvalid && s_axis_tready;
    assign busy = (state != IDLE);

    // The destination MAC is complete long before byte 13, so the filter
    // decision can be taken straight from the header register.
    assign dest_ok = !FILTER_EN || (m_eth_dest_mac == local_mac) ||
                     (m_eth_dest_mac == 48'hFFFF_FFFF_FFFF);

    // Input back-pressure: IDLE holds off a new header while the previous
    // one is still pending, PAYLOAD follows the single output register.
    always_comb begin
        s_axis_tready = 1'b0;
        if (!reset) begin
            case (state)
                IDLE:    s_axis_tready = !m_eth_hdr_valid;
                HDR:     s_axis_tready = 1'b1;
                PAYLOAD: s_axis_tready = !m_eth_axi_payload_tvalid || m_eth_axi_payload_tready;
                DROP:    s_axis_tready = 1'b1;
                default: s_axis_tready = 1'b0;
            endcase
        end
    end

    // Frame FSM, header field shift registers and payload output stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                     <= IDLE;
            cnt                       <= 4'd0;
            first_pl                  <= 1'b0;
            m_eth_hdr_valid           <= 1'b0;
            m_eth_dest_mac            <= 48'd0;
            m_eth_src_mac             <= 48'd0;
            m_eth_type                <= 16'd0;
            m_eth_axi_payload_tdata   <= 8'd0;
            m_eth_axi_payload_tvalid  <= 1'b0;
            m_eth_axi_payload_tlast   <= 1'b0;
            m_eth_axi_payload_tuser   <= 1'b0;
            err_hdr_early_termination <= 1'b0;
        end else begin
            err_hdr_early_termination <= 1'b0;
            if (m_eth_hdr_valid && m_eth_hdr_ready)
                m_eth_hdr_valid <= 1'b0;
            if (m_eth_axi_payload_tready)
                m_eth_axi_payload_tvalid <= 1'b0;

            case (state)
                IDLE: begin
                    if (xfer) begin
                        m_eth_dest_mac <= {m_eth_dest_mac[39:0], s_axis_tdata};
                        if (s_axis_tlast) begin
                            err_hdr_early_termination <= 1'b1;
                        end else begin
                            cnt   <= 4'd1;
                            state <= HDR;
                        end
                    end
                end
                HDR: begin
                    if (xfer) begin
                        // Fields are shifted in MSB-first; hdr_valid is known
                        // low here, so the outputs are free to change.
                        if (cnt < 4'd6)
                            m_eth_dest_mac <= {m_eth_dest_mac[39:0], s_axis_tdata};
                        else if (cnt < 4'd12)
                            m_eth_src_mac <= {m_eth_src_mac[39:0], s_axis_tdata};
                        else
                            m_eth_type <= {m_eth_type[7:0], s_axis_tdata};
                        cnt <= cnt + 4'd1;
                        if (s_axis_tlast) begin
                            err_hdr_early_termination <= 1'b1;
                            cnt                       <= 4'd0;
                            state                     <= IDLE;
                        end else if (cnt == 4'd13) begin
                            cnt <= 4'd0;
                            if (dest_ok) begin
                                m_eth_hdr_valid <= 1'b1;
                                first_pl        <= 1'b1;
                                state           <= PAYLOAD;
                            end else begin
                                state <= DROP;
                            end
                        end
                    end
                end
                PAYLOAD: begin
                    if (xfer) begin
                        m_eth_axi_payload_tdata  <= s_axis_tdata;
                        m_eth_axi_payload_tvalid <= 1'b1;
                        m_eth_axi_payload_tlast  <= s_axis_tlast;
                        m_eth_axi_payload_tuser  <= first_pl;
                        first_pl                 <= 1'b0;
                        if (s_axis_tlast)
                            state <= IDLE;
                    end
                end
                DROP: begin
                    if (xfer && s_axis_tlast)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_frame_rx.sv
// Scoreboard bench for eth_frame_rx (filter enabled): expected headers and
// payload bytes are queued as frames are driven and checked at handshakes.
module tb_eth_frame_rx;

    localparam logic [47:0] LOCAL = 48'h0200_0000_0001;

    logic        clk = 1'b0;
    logic        reset;
    logic [47:0] local_mac;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic        m_eth_hdr_valid, m_eth_hdr_ready;
    logic [47:0] m_eth_dest_mac, m_eth_src_mac;
    logic [15:0] m_eth_type;
    logic [7:0]  pl_data;
    logic        pl_valid, pl_ready, pl_last, pl_user;
    logic        busy, err;

    eth_frame_rx #(.FILTER_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .local_mac(local_mac),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_eth_hdr_valid(m_eth_hdr_valid), .m_eth_hdr_ready(m_eth_hdr_ready),
        .m_eth_dest_mac(m_eth_dest_mac), .m_eth_src_mac(m_eth_src_mac),
        .m_eth_type(m_eth_type),
        .m_eth_axi_payload_tdata(pl_data), .m_eth_axi_payload_tvalid(pl_valid),
        .m_eth_axi_payload_tready(pl_ready), .m_eth_axi_payload_tlast(pl_last),
        .m_eth_axi_payload_tuser(pl_user),
        .busy(busy), .err_hdr_early_termination(err)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [47:0] d;
        logic [47:0] s;
        logic [15:0] t;
    } hdr_t;

    logic [7:0] frm[$];
    hdr_t       hq[$];
    logic [9:0] pq[$];          // {tuser, tlast, data}
    hdr_t       hx;
    logic [9:0] px;
    int         n_vec = 0, n_bad = 0;
    int         err_seen = 0, exp_err = 0;
    bit         rand_en = 1'b0;
    bit         drop_chk = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mk(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t, input int npl);
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(d[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(s[47-8*i -: 8]);
        frm.push_back(t[15:8]);
        frm.push_back(t[7:0]);
        for (int i = 0; i < npl; i++) frm.push_back(8'($urandom_range(0, 255)));
    endtask

    // Drives frm byte by byte; stop_after >= 0 leaves the frame unfinished.
    task automatic send(input int stop_after);
        int          n;
        logic [47:0] d;
        bit          pass;
        hdr_t        h;
        n = frm.size();
        d = 48'd0;
        for (int i = 0; i < 6 && i < n; i++) d = {d[39:0], frm[i]};
        pass = (d == LOCAL) || (d == 48'hFFFF_FFFF_FFFF);
        if (n <= 14) exp_err++;
        else if (pass) begin
            h.d = d;
            h.s = {frm[6], frm[7], frm[8], frm[9], frm[10], frm[11]};
            h.t = {frm[12], frm[13]};
            hq.push_back(h);
            for (int i = 14; i < n; i++) pq.push_back({i == 14, i == n - 1, frm[i]});
        end
        for (int i = 0; i < n; i++) begin
            int k;
            if (stop_after >= 0 && i >= stop_after) break;
            s_axis_tdata  = frm[i];
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = (i == n - 1);
            k = 0;
            forever begin
                @(negedge clk);
                if (drop_chk) chk("drop_tready", s_axis_tready, 1);
                if (s_axis_tready) break;
                k++;
                if (k > 300) break;
            end
            if (!s_axis_tready) begin
                chk("tready_timeout", s_axis_tready, 1);
                break;
            end
            @(posedge clk); #1;
            if (n > 14 && i == 13) chk(pass ? "hdr_latency" : "drop_no_hdr", m_eth_hdr_valid, pass);
            if (n > 14 && i >= 14 && pass) chk("pl_latency", {pl_valid, pl_data}, {1'b1, frm[i]});
            if (n > 14 && i >= 14 && !pass) chk("drop_pl_idle", pl_valid, 0);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k = 0;
        while ((hq.size() != 0 || pq.size() != 0) && k < 500) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("hdr_queue_empty", hq.size(), 0);
        chk("pl_queue_empty", pq.size(), 0);
    endtask

    // Output monitor: pops the scoreboard on every completed handshake.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (err) err_seen++;
            if (m_eth_hdr_valid && m_eth_hdr_ready) begin
                if (hq.size() == 0) chk("hdr_unexpected", m_eth_hdr_valid, 0);
                else begin
                    hx = hq.pop_front();
                    chk("hdr_dest", m_eth_dest_mac, hx.d);
                    chk("hdr_src", m_eth_src_mac, hx.s);
                    chk("hdr_type", m_eth_type, hx.t);
                end
            end
            if (pl_valid && pl_ready) begin
                if (pq.size() == 0) chk("pl_unexpected", pl_valid, 0);
                else begin
                    px = pq.pop_front();
                    chk("pl_byte", {pl_user, pl_last, pl_data}, px);
                end
            end
        end
    end

    // Payload sink ready: always ready, or random when rand_en is set.
    initial forever begin
        @(posedge clk);
        #1;
        pl_ready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin
        reset           = 1'b1;
        local_mac       = LOCAL;
        s_axis_tdata    = 8'd0;
        s_axis_tvalid   = 1'b0;
        s_axis_tlast    = 1'b0;
        m_eth_hdr_ready = 1'b1;
        pl_ready        = 1'b1;
        cycles(3);
        chk("rst_tready", s_axis_tready, 0);
        chk("rst_hdr_valid", m_eth_hdr_valid, 0);
        chk("rst_pl_valid", {pl_valid, pl_last, pl_user}, 0);
        chk("rst_busy_err", {busy, err}, 0);
        chk("rst_fields", {m_eth_dest_mac, m_eth_type}, 0);
        chk("rst_src_data", {m_eth_src_mac, pl_data}, 0);
        reset = 1'b0;
        cycles(1);

        // Reference frame: AA(sof) BB CC(eof)
        mk(48'h0200_0000_0001, 48'h0200_0000_0002, 16'h0800, 0);
        frm.push_back(8'hAA); frm.push_back(8'hBB); frm.push_back(8'hCC);
        send(-1);
        drain();

        // Truncated headers: tlast on byte 9, byte 13 and byte 0
        mk(LOCAL, 48'h0200_0000_0002, 16'h0800, 5);
        while (frm.size() > 10) void'(frm.pop_back());
        send(-1);
        cycles(4);
        chk("err_pulse_b9", err_seen, exp_err);
        mk(LOCAL, 48'h0A0B_0C0D_0E0F, 16'h86DD, 6);
        send(-1);
        drain();
        mk(LOCAL, 48'h0200_0000_0003, 16'h0806, 0);
        send(-1);
        cycles(4);
        chk("err_pulse_b13", err_seen, exp_err);
        frm.delete(); frm.push_back(8'h55);
        send(-1);
        cycles(4);
        chk("err_pulse_b0", err_seen, exp_err);
        mk(LOCAL, 48'h1122_3344_5566, 16'h0800, 1);
        send(-1);
        drain();

        // Filtered destination, then broadcast
        drop_chk = 1'b1;
        mk(48'h0200_0000_0099, 48'h0200_0000_0002, 16'h0800, 4);
        send(-1);
        drop_chk = 1'b0;
        cycles(2);
        chk("drop_busy_clear", busy, 0);
        mk(48'hFFFF_FFFF_FFFF, 48'h0200_0000_0007, 16'h0806, 3);
        send(-1);
        drain();

        // Header sink stalled with two back-to-back frames
        m_eth_hdr_ready = 1'b0;
        mk(LOCAL, 48'h0200_0000_0011, 16'h0800, 4);
        send(-1);
        cycles(3);
        chk("stall_f1_payload_done", pq.size(), 0);
        chk("stall_hdr_pending", m_eth_hdr_valid, 1);
        mk(LOCAL, 48'h0200_0000_0022, 16'h0801, 3);
        fork
            send(-1);
            begin
                repeat (17) @(posedge clk);
                @(negedge clk);
                chk("stall_tready", s_axis_tready, 0);
                chk("stall_not_busy", busy, 0);
                @(posedge clk); #1;
                m_eth_hdr_ready = 1'b1;
            end
        join
        drain();

        // Random payload back-pressure
        rand_en = 1'b1;
        for (int f = 0; f < 3; f++) begin
            mk(LOCAL, 48'h0200_0000_0030 + 48'(f), 16'h0800 + 16'(f), 20);
            send(-1);
        end
        drain();
        rand_en = 1'b0;
        cycles(2);

        // Reset mid-payload (payload byte 2 pending)
        mk(LOCAL, 48'h0200_0000_0044, 16'h0800, 5);
        send(16);
        #2 reset = 1'b1;
        #1;
        chk("arst_valids", {m_eth_hdr_valid, pl_valid, pl_last, pl_user}, 0);
        chk("arst_tready_busy", {s_axis_tready, busy, err}, 0);
        chk("arst_data", {m_eth_dest_mac, pl_data}, 0);
        hq.delete();
        pq.delete();
        cycles(2);
        reset = 1'b0;
        cycles(1);
        mk(LOCAL, 48'h0200_0000_0055, 16'h0800, 3);
        send(-1);
        drain();
        cycles(3);
        chk("err_total", err_seen, exp_err);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
